pla_seq_eval: RTL and testbench
===============================

Name: pla_seq_eval

Overview:
- Programmable, sequential successor to the flat mockturtle-optimised single-output PLA netlists.
- Holds a cube table of DEPTH product terms, each with a care mask, a value mask, an output mask and an enable bit.
- Evaluates each accepted N_IN-bit input vector against the table at one cube per cycle, in OR (SOP) or XOR (ESOP) accumulation mode, and returns an N_OUT-bit result over a valid/ready handshake.
- Sits between the benchmark stimulus driver and the result checker, so table contents can be swapped without resynthesis.

Parameters:
- N_IN, 16, input vector width (x bits).
- N_OUT, 1, output vector width (y bits).
- DEPTH, 32, number of cube entries; minimum 2.
- AW, $clog2(DEPTH), cube address width; derived, not to be overridden.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- cfg_we  in  1  cube write strobe.
- cfg_addr  in  AW  cube index to write.
- cfg_care  in  N_IN  care mask; 1 = literal present.
- cfg_val  in  N_IN  literal polarity for cared bits.
- cfg_out  in  N_OUT  outputs the cube contributes to.
- cfg_en  in  1  cube enable.
- cfg_err  out  1  one-cycle pulse when a write is dropped.
- mode  in  1  0 = OR (SOP), 1 = XOR (ESOP); sampled at accept.
- in_valid  in  1  input vector valid.
- in_ready  out  1  block can accept a vector.
- x  in  N_IN  input vector.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- y  out  N_OUT  result vector.
- busy  out  1  high in SCAN or DONE.

Behaviour:
- Reset, synchronous:
  - state = IDLE; all cube enables cleared; other table fields don't-care.
  - y = 0, out_valid = 0, cfg_err = 0, busy = 0.
  - in_ready reads 1 from the first cycle after reset deasserts.
- Cube match: en[i] && (((x_l ^ val[i]) & care[i]) == 0), where x_l is the latched input. care = 0 with en = 1 matches every vector.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid && in_ready: latch x_l = x and mode_l = mode; set acc = 0, idx = 0; go to SCAN.
- SCAN:
  - in_ready = 0.
  - Each cycle processes cube idx: if matched, acc = acc | out[idx] when mode_l = 0, else acc = acc ^ out[idx].
  - idx increments each cycle.
  - On the cycle that processes idx = DEPTH-1: y is loaded with the final acc (including that cube's contribution) and state goes to DONE.
- DONE:
  - out_valid = 1 and y is held stable.
  - On out_ready: out_valid = 0 next cycle and state goes to IDLE.
  - No same-cycle re-accept: the next vector is taken at earliest one cycle after the handshake.
- Latency:
  - Acceptance edge k; out_valid is first high after edge k+DEPTH.
  - With out_ready held high, the throughput is one result per DEPTH+2 cycles.
- y changes only on the SCAN-to-DONE transition and on reset; it is not cleared in IDLE.
- Config writes:
  - Accepted only in IDLE: table[cfg_addr] updated at the edge and visible to the next accepted vector.
  - Dropped, with cfg_err pulsing for one cycle, if the state is SCAN or DONE, or if cfg_addr >= DEPTH (non-power-of-2 DEPTH).
  - A write in IDLE coinciding with an input accept is applied before the scan starts.
- mode changes after the accept have no effect on the in-flight evaluation.
- Reset mid-SCAN or mid-DONE:
  - Evaluation is abandoned and out_valid drops at that edge.
  - The table is cleared; the result is never delivered.
- X on x or cfg_* while the associated valid/we is low must not propagate into state.

Test Plan:
- Reset, then evaluate x = 0x0000 with mode 0 -> after 32 cycles y = 0 (all cubes disabled); in_ready = 1 one cycle after reset release.
- Write cube 0: care = 0x008B, val = 0x0083, out = 1, en = 1. Evaluate x = 0x0083 -> y = 1 at exactly edge k+32. Evaluate x = 0x008B -> y = 0.
- Add cube 5: care = 0x0001, val = 0x0001, out = 1. Evaluate x = 0x0083 with mode 0 -> y = 1; same x with mode 1 -> y = 0 (two matches cancel). x = 0x0001 with mode 1 -> y = 1.
- Hold out_ready = 0 for 5 cycles in DONE -> y and out_valid stable, in_ready = 0, busy = 1. Release -> out_valid = 0 next cycle, then in_ready = 1.
- cfg_we to cube 0 with en = 0 issued mid-SCAN -> cfg_err pulses for 1 cycle; the in-flight and the next result still see cube 0 enabled (y = 1 for x = 0x0083).
- Assert rst at SCAN cycle 10 -> out_valid never rises for that vector; the subsequent evaluation of x = 0x0083 gives y = 0.

Source files
------------

// File: rtl/pla_seq_eval_if.sv
`default_nettype none
// ============================================================================
// Module   : pla_seq_eval_if
// Brief    : Cube-table configuration, input-vector and result handshakes
//            for pla_seq_eval.
// Revision : 1.0 - initial release
// ============================================================================
interface pla_seq_eval_if #(
    parameter int N_IN  = 16,
    parameter int N_OUT = 1,
    parameter int DEPTH = 32
);
    localparam int AW = $clog2(DEPTH);

    logic             cfg_we;
    logic [AW-1:0]    cfg_addr;
    logic [N_IN-1:0]  cfg_care;
    logic [N_IN-1:0]  cfg_val;
    logic [N_OUT-1:0] cfg_out;
    logic             cfg_en;
    logic             cfg_err;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [N_IN-1:0]  x;
    logic             out_valid;
    logic             out_ready;
    logic [N_OUT-1:0] y;
    logic             busy;

    modport master (
        output cfg_we, cfg_addr, cfg_care, cfg_val, cfg_out, cfg_en,
        output mode, in_valid, x, out_ready,
        input  cfg_err, in_ready, out_valid, y, busy
    );

    modport slave (
        input  cfg_we, cfg_addr, cfg_care, cfg_val, cfg_out, cfg_en,
        input  mode, in_valid, x, out_ready,
        output cfg_err, in_ready, out_valid, y, busy
    );
endinterface
`default_nettype wire

// File: rtl/pla_seq_eval.sv
`default_nettype none
// ============================================================================
// Module   : pla_seq_eval
// Brief    : Programmable cube-table PLA evaluated one cube per cycle in
//            SOP (OR) or ESOP (XOR) accumulation mode.
// Revision : 1.0 - initial release
// ============================================================================
module pla_seq_eval #(
    parameter  int N_IN  = 16,
    parameter  int N_OUT = 1,
    parameter  int DEPTH = 32,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst,
    pla_seq_eval_if.slave    bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] c_last  = AW'(DEPTH - 1);
    localparam logic [AW:0]   c_depth = (AW + 1)'(DEPTH);

    state_t           r_state;
    state_t           w_state_next;

    logic [N_IN-1:0]  r_care [DEPTH];
    logic [N_IN-1:0]  r_val  [DEPTH];
    logic [N_OUT-1:0] r_out  [DEPTH];
    logic [DEPTH-1:0] r_en;

    logic [N_IN-1:0]  r_x;
    logic             r_mode;
    logic [N_OUT-1:0] r_acc;
    logic [AW-1:0]    r_idx;
    logic [N_OUT-1:0] r_y;
    logic             r_cfg_err;

    logic             w_accept;
    logic             w_addr_ok;
    logic             w_cfg_ok;
    logic             w_hit;
    logic [N_OUT-1:0] w_contrib;
    logic [N_OUT-1:0] w_acc_next;
    logic             w_in_ready;
    logic             w_out_valid;
    logic             w_busy;

    // Non-power-of-2 tables leave addresses that decode to no entry.
    assign w_addr_ok = ({1'b0, bus.cfg_addr} < c_depth);
    assign w_cfg_ok  = bus.cfg_we && (r_state == S_IDLE) && w_addr_ok;
    assign w_accept  = (r_state == S_IDLE) && bus.in_valid;

    assign w_hit      = r_en[r_idx] && (((r_x ^ r_val[r_idx]) & r_care[r_idx]) == '0);
    assign w_contrib  = w_hit ? r_out[r_idx] : '0;
    assign w_acc_next = r_mode ? (r_acc ^ w_contrib) : (r_acc | w_contrib);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                w_busy = 1'b1;
                if (r_idx == c_last) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                w_busy      = 1'b1;
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_x       <= '0;
            r_mode    <= 1'b0;
            r_acc     <= '0;
            r_idx     <= '0;
            r_y       <= '0;
            r_cfg_err <= 1'b0;
        end else begin
            r_cfg_err <= bus.cfg_we && !w_cfg_ok;
            if (w_accept) begin
                r_x    <= bus.x;
                r_mode <= bus.mode;
                r_acc  <= '0;
                r_idx  <= '0;
            end else if (r_state == S_SCAN) begin
                r_acc <= w_acc_next;
                r_idx <= r_idx + 1'b1;
                // y carries the last cube's contribution and then holds.
                if (r_idx == c_last) begin
                    r_y <= w_acc_next;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_en <= '0;
        end else if (w_cfg_ok) begin
            r_en[bus.cfg_addr] <= bus.cfg_en;
        end
    end

    // Only enables need reset; the remaining fields are ignored while disabled.
    always_ff @(posedge clk) begin
        if (w_cfg_ok) begin
            r_care[bus.cfg_addr] <= bus.cfg_care;
            r_val[bus.cfg_addr]  <= bus.cfg_val;
            r_out[bus.cfg_addr]  <= bus.cfg_out;
        end
    end

    assign bus.in_ready  = w_in_ready;
    assign bus.out_valid = w_out_valid;
    assign bus.busy      = w_busy;
    assign bus.y         = r_y;
    assign bus.cfg_err   = r_cfg_err;
endmodule
`default_nettype wire

// File: tb/tb_pla_seq_eval.sv
`default_nettype none
// ============================================================================
// Module   : tb_pla_seq_eval
// Brief    : Directed self-checking bench for pla_seq_eval.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pla_seq_eval;
    localparam int N_IN  = 16;
    localparam int N_OUT = 1;
    localparam int DEPTH = 32;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    pla_seq_eval_if #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH)) bus ();

    pla_seq_eval #(.N_IN(N_IN), .N_OUT(N_OUT), .DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, need $finish");
        $fatal(1);
    end

    task automatic write_cube(input logic [4:0] a, input logic [15:0] care,
                              input logic [15:0] val, input logic o, input logic en);
        @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = a;
        bus.cfg_care = care;
        bus.cfg_val  = val;
        bus.cfg_out  = o;
        bus.cfg_en   = en;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
        bus.cfg_addr = 'x;
        bus.cfg_care = 'x;
        bus.cfg_val  = 'x;
        bus.cfg_out  = 'x;
        bus.cfg_en   = 1'bx;
    endtask

    // Returns at the falling edge right after the accepting rising edge.
    task automatic start_vec(input logic [15:0] xv, input logic m);
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.x        = xv;
        bus.mode     = m;
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.x        = 'x;
        bus.mode     = ~m;
    endtask

    task automatic wait_result(output int n, output logic yv, output bit to);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        to = (bus.out_valid !== 1'b1);
        yv = bus.y;
    endtask

    task automatic ack;
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
    endtask

    task automatic eval(input logic [15:0] xv, input logic m,
                        output int lat, output logic yv, output bit to);
        start_vec(xv, m);
        wait_result(lat, yv, to);
        ack();
    endtask

    task automatic test_reset;
        int   lat;
        logic yv;
        bit   to;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b need 1", bus.in_ready); end
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b need 0", bus.out_valid); end
        checks++; if (bus.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b need 0", bus.busy); end
        checks++; if (bus.y !== 1'b0) begin errors++; $display("FAIL reset_y: got %b need 0", bus.y); end
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL reset_cfg_err: got %b need 0", bus.cfg_err); end
        eval(16'h0000, 1'b0, lat, yv, to);
        checks++; if (to) begin errors++; $display("FAIL empty_table_timeout: got no out_valid, need out_valid"); end
        checks++; if (yv !== 1'b0) begin errors++; $display("FAIL empty_table_y: got %b need 0", yv); end
    endtask

    task automatic test_single_cube;
        int   lat;
        logic yv;
        bit   to;
        write_cube(5'd0, 16'h008B, 16'h0083, 1'b1, 1'b1);
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL idle_write_err: got %b need 0", bus.cfg_err); end
        eval(16'h0083, 1'b0, lat, yv, to);
        checks++; if (to || lat != DEPTH) begin errors++; $display("FAIL latency: got %0d need %0d", lat, DEPTH); end
        checks++; if (yv !== 1'b1) begin errors++; $display("FAIL cube0_match_y: got %b need 1", yv); end
        eval(16'h008B, 1'b0, lat, yv, to);
        checks++; if (to || yv !== 1'b0) begin errors++; $display("FAIL cube0_miss_y: got %b need 0", yv); end
    endtask

    task automatic test_mode;
        int   lat;
        logic yv;
        bit   to;
        write_cube(5'd5, 16'h0001, 16'h0001, 1'b1, 1'b1);
        eval(16'h0083, 1'b0, lat, yv, to);
        checks++; if (to || yv !== 1'b1) begin errors++; $display("FAIL sop_two_hits_y: got %b need 1", yv); end
        eval(16'h0083, 1'b1, lat, yv, to);
        checks++; if (to || yv !== 1'b0) begin errors++; $display("FAIL esop_cancel_y: got %b need 0", yv); end
        eval(16'h0001, 1'b1, lat, yv, to);
        checks++; if (to || yv !== 1'b1) begin errors++; $display("FAIL esop_single_y: got %b need 1", yv); end
        repeat (3) @(negedge clk);
        checks++; if (bus.y !== 1'b1) begin errors++; $display("FAIL idle_y_hold: got %b need 1", bus.y); end
    endtask

    task automatic test_backpressure;
        int   lat;
        logic yv;
        bit   to;
        start_vec(16'h0083, 1'b0);
        wait_result(lat, yv, to);
        checks++; if (to || yv !== 1'b1) begin errors++; $display("FAIL bp_y: got %b need 1", yv); end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            checks++;
            if (bus.out_valid !== 1'b1 || bus.y !== 1'b1 || bus.in_ready !== 1'b0 || bus.busy !== 1'b1) begin
                errors++;
                $display("FAIL bp_hold[%0d]: got v=%b y=%b rdy=%b busy=%b need 1 1 0 1",
                         i, bus.out_valid, bus.y, bus.in_ready, bus.busy);
            end
        end
        ack();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bp_release_valid: got %b need 0", bus.out_valid); end
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready: got %b need 1", bus.in_ready); end
    endtask

    task automatic test_cfg_drop;
        int   lat;
        logic yv;
        bit   to;
        start_vec(16'h0083, 1'b0);
        repeat (4) @(negedge clk);
        bus.cfg_we   = 1'b1;
        bus.cfg_addr = 5'd0;
        bus.cfg_care = 16'h0000;
        bus.cfg_val  = 16'h0000;
        bus.cfg_out  = 1'b0;
        bus.cfg_en   = 1'b0;
        @(negedge clk);
        bus.cfg_we   = 1'b0;
        checks++; if (bus.cfg_err !== 1'b1) begin errors++; $display("FAIL drop_err_pulse: got %b need 1", bus.cfg_err); end
        @(negedge clk);
        checks++; if (bus.cfg_err !== 1'b0) begin errors++; $display("FAIL drop_err_width: got %b need 0", bus.cfg_err); end
        wait_result(lat, yv, to);
        ack();
        checks++; if (to || lat + 6 != DEPTH) begin errors++; $display("FAIL drop_latency: got %0d need %0d", lat + 6, DEPTH); end
        checks++; if (yv !== 1'b1) begin errors++; $display("FAIL drop_inflight_y: got %b need 1", yv); end
        eval(16'h0083, 1'b0, lat, yv, to);
        checks++; if (to || yv !== 1'b1) begin errors++; $display("FAIL drop_next_y: got %b need 1", yv); end
    endtask

    task automatic test_reset_mid_scan;
        int   lat;
        logic yv;
        bit   to;
        bit   seen;
        start_vec(16'h0083, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        checks++; if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin errors++; $display("FAIL rst_scan_state: got busy=%b v=%b need 0 0", bus.busy, bus.out_valid); end
        checks++; if (bus.y !== 1'b0) begin errors++; $display("FAIL rst_scan_y: got %b need 0", bus.y); end
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) seen = 1'b1;
        end
        checks++; if (seen) begin errors++; $display("FAIL rst_scan_no_result: got out_valid=1 need 0"); end
        eval(16'h0083, 1'b0, lat, yv, to);
        checks++; if (to || yv !== 1'b0) begin errors++; $display("FAIL rst_table_cleared_y: got %b need 0", yv); end
    endtask

    task automatic test_back_to_back;
        int   first;
        int   second;
        logic y1;
        logic y2;
        write_cube(5'd0, 16'h008B, 16'h0083, 1'b1, 1'b1);
        first  = -1;
        second = -1;
        y1     = 1'b0;
        y2     = 1'b0;
        @(negedge clk);
        bus.x         = 16'h0083;
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        for (int c = 1; c <= 120 && second < 0; c++) begin
            @(negedge clk);
            if (bus.out_valid === 1'b1) begin
                if (first < 0) begin
                    first = c;
                    y1    = bus.y;
                end else begin
                    second = c;
                    y2     = bus.y;
                end
            end
        end
        bus.in_valid = 1'b0;
        bus.x        = 'x;
        for (int c = 0; c < 100 && bus.busy !== 1'b0; c++) @(negedge clk);
        bus.out_ready = 1'b0;
        checks++; if (first != DEPTH + 1) begin errors++; $display("FAIL b2b_first: got %0d need %0d", first, DEPTH + 1); end
        checks++; if (second - first != DEPTH + 2) begin errors++; $display("FAIL b2b_period: got %0d need %0d", second - first, DEPTH + 2); end
        checks++; if (y1 !== 1'b1 || y2 !== 1'b1) begin errors++; $display("FAIL b2b_y: got %b %b need 1 1", y1, y2); end
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst           = 1'b1;
        bus.cfg_we    = 1'b0;
        bus.cfg_addr  = '0;
        bus.cfg_care  = '0;
        bus.cfg_val   = '0;
        bus.cfg_out   = '0;
        bus.cfg_en    = 1'b0;
        bus.mode      = 1'b0;
        bus.in_valid  = 1'b0;
        bus.x         = '0;
        bus.out_ready = 1'b0;

        test_reset();
        test_single_cube();
        test_mode();
        test_backpressure();
        test_cfg_drop();
        test_reset_mid_scan();
        test_back_to_back();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
